// File: rtl/cpu_multicycle.sv
// Multicycle 16-bit-ISA CPU: FETCH/DECODE/EXEC/MEM/WB sequencer over a WIDTH-bit datapath,
// with an external combinational instruction ROM and a req/ready data-memory port.
`timescale 1ns/1ps
module cpu_multicycle #(
   parameter int WIDTH  = 16,
   parameter int PC_W   = 9,
   parameter int ADDR_W = 9
) (
   input  logic              clock,
   input  logic              reset,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   input  logic              mem_ready,
   output logic [15:0]       instr_reg,
   output logic [WIDTH-1:0]  write_data,
   output logic              retire,
   output logic              halted
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} stateT;

   stateT                 state;
   logic [PC_W-1:0]       pc;
   logic [3:0][WIDTH-1:0] regFile;
   logic [WIDTH-1:0]      aReg, bReg, aluOut, mdr;

   logic [3:0]       op;
   logic [1:0]       rs, rt, rd, dest;
   logic [WIDTH-1:0] immW, aluRes, wbVal;
   logic [PC_W-1:0]  immPc;
   logic             isBranch, isNop, isLoad, isStore, takeBranch;

   assign op       = instr_reg[15:12];
   assign rs       = instr_reg[11:10];
   assign rt       = instr_reg[9:8];
   assign rd       = instr_reg[7:6];
   assign immW     = WIDTH'($signed(instr_reg[7:0]));
   assign immPc    = PC_W'($signed(instr_reg[7:0]));
   assign isBranch = (op == 4'h8) || (op == 4'h9);
   assign isNop    = (op >= 4'hA) && (op <= 4'hE);
   assign isLoad   = (op == 4'h5);
   assign isStore  = (op == 4'h6);
   assign takeBranch = ((op == 4'h8) && (aReg == bReg)) || ((op == 4'h9) && (aReg != bReg));

   // addi and loads target rt; the three-register ops target rd
   assign dest  = (op == 4'h4 || isLoad) ? rt : rd;
   assign wbVal = isLoad ? mdr : aluOut;

   always_comb begin
      aluRes = '0;
      case (op)
         4'h0:                aluRes = aReg + bReg;
         4'h1, 4'h8, 4'h9:    aluRes = aReg - bReg;
         4'h2:                aluRes = aReg & bReg;
         4'h3:                aluRes = aReg | bReg;
         4'h4, 4'h5, 4'h6:    aluRes = aReg + immW;
         4'h7:                aluRes = ($signed(aReg) < $signed(bReg)) ? WIDTH'(1) : '0;
         default:             aluRes = '0;
      endcase
   end

   // Memory port is a pure decode of the state register, so an async reset drops it at once
   assign mem_req   = (state == MEM);
   assign mem_we    = mem_req && isStore;
   assign mem_addr  = ADDR_W'(aluOut);
   assign mem_wdata = bReg;
   assign imem_addr = pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= '0;
         instr_reg  <= '0;
         regFile    <= '0;
         aReg       <= '0;
         bReg       <= '0;
         aluOut     <= '0;
         mdr        <= '0;
         write_data <= '0;
         retire     <= 1'b0;
         halted     <= 1'b0;
      end else begin
         retire <= 1'b0;
         unique case (state)
            FETCH: begin
               instr_reg <= imem_data;
               pc        <= pc + PC_W'(1);
               state     <= DECODE;
            end
            DECODE: begin
               aReg <= regFile[rs];
               bReg <= regFile[rt];
               if (op == 4'hF) begin
                  state  <= HALTED;
                  retire <= 1'b1;
                  halted <= 1'b1;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               aluOut <= aluRes;
               if (isBranch || isNop) begin
                  if (takeBranch) pc <= immPc;
                  retire <= 1'b1;
                  state  <= FETCH;
               end else if (isLoad || isStore) begin
                  state <= MEM;
               end else begin
                  state <= WB;
               end
            end
            MEM: begin
               if (mem_ready) begin
                  if (isLoad) begin
                     mdr   <= mem_rdata;
                     state <= WB;
                  end else begin
                     retire <= 1'b1;
                     state  <= FETCH;
                  end
               end
            end
            WB: begin
               regFile[dest] <= wbVal;
               write_data    <= wbVal;
               retire        <= 1'b1;
               state         <= FETCH;
            end
            HALTED: state <= HALTED;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multicycle successor to the team's single-cycle 16-bit CPU. It executes the same 16-bit instruction set, plus a new HALT opcode, over a WIDTH-bit datapath. Each instruction is sequenced through a fetch/decode/execute/memory/writeback state machine. Data memory moves outside the core behind a req/ready handshake, so wait states of any length are tolerated. Instruction memory is an external combinational ROM port.

## Interface
- WIDTH, 16: datapath, register and data-memory word width; must be at least 8.
- PC_W, 9: instruction address width.
- ADDR_W, 9: data address width.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_addr  out  PC_W  current PC.
- imem_data  in  16  instruction at imem_addr, combinational.
- mem_req  out  1  data access request.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  ADDR_W  ALU result [ADDR_W-1:0].
- mem_wdata  out  WIDTH  store data (rt value).
- mem_rdata  in  WIDTH  load data; valid in the cycle mem_ready is high.
- mem_ready  in  1  completes the access in the cycle it is sampled high with mem_req.
- instr_reg  out  16  latched instruction register.
- write_data  out  WIDTH  last value written to the register file; holds between writes.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high once HALT retires.

## Operation
- Instruction fields: op [15:12], rs [11:10], rt [9:8], rd [7:6], imm [7:0].
- Register file: 4 x WIDTH. All four registers are writable, and all reset to 0.
- imm is sign-extended to WIDTH bits for the ALU and to PC_W bits for branch targets.
- Opcodes:
  - 0 add: rd = rs + rt.
  - 1 sub: rd = rs - rt.
  - 2 and: rd = rs & rt.
  - 3 or: rd = rs | rt.
  - 4 addi: rt = rs + imm.
  - 5 lw: rt = M[rs + imm].
  - 6 sw: M[rs + imm] = rt.
  - 7 slt: rd = (signed rs < signed rt) ? 1 : 0.
  - 8 beq: PC = imm if rs == rt.
  - 9 bne: PC = imm if rs != rt.
  - F halt.
  - A to E: NOP.
- Arithmetic wraps modulo 2^WIDTH; overflow is ignored.
- Branch targets are absolute, not PC-relative. A not-taken branch and every non-branch instruction set PC = PC+1, which wraps modulo 2^PC_W.
- States and transitions:
  - FETCH: IR <= imem_data, PC <= PC+1 → DECODE.
  - DECODE: A <= reg[rs], B <= reg[rt] → EXEC. A HALT opcode goes to HALTED instead.
  - EXEC: ALUOut <= result.
    - Branch and NOP: the PC update happens here → FETCH.
    - lw/sw → MEM.
    - All others → WB.
  - MEM: mem_req = 1.
    - Hold the state, and hold mem_addr/mem_we/mem_wdata stable, until mem_ready = 1.
    - lw: MDR <= mem_rdata → WB.
    - sw → FETCH.
  - WB: reg[dest] <= (lw ? MDR : ALUOut), write_data <= the same value → FETCH.
  - HALTED: absorbing state; no fetch, no memory access. Only reset exits.
- retire is asserted for exactly one cycle on every transition into FETCH from EXEC, MEM or WB, and on entry to HALTED.
- mem_ready is ignored while mem_req is low.

## Timing
- Reset values: PC 0, state FETCH, IR 0, all registers 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, write_data 0, retire 0, halted 0.
- Reset is asynchronous. Asserting it mid-MEM drops mem_req in the same cycle and abandons the access.
- Latency in cycles, from FETCH to retire:
  - branch/NOP: 3.
  - ALU ops and addi: 4.
  - sw: 4 + wait cycles.
  - lw: 5 + wait cycles.
  - halt: 2.
  - "wait cycles" is the number of MEM cycles with mem_ready low.
- With mem_ready tied high, MEM lasts exactly one cycle.
- mem_req is a registered-state decode: high exactly while the state is MEM.
- A register written in WB is visible to the next instruction's DECODE, so there are no hazards.
- Back-to-back accesses always have at least 3 non-MEM cycles between them.

## Test plan
- Arithmetic (WIDTH=16, mem_ready=1): program 0x4107, 0x0580.
  - Required: r1 = 0x0007, then write_data = 0x000E (r2).
  - retire fires at cycles 4 and 8 after reset release.
- Load with wait states: 0x5302, mem_ready held low for 3 MEM cycles and then high with mem_rdata = 0xBEEF.
  - Required: mem_req high for 4 cycles, mem_addr = 2, mem_we = 0.
  - Required: r3 = write_data = 0xBEEF; retire fires 8 cycles after the fetch.
- Store: r1 = 7, then 0x6105.
  - Required: mem_req = 1, mem_we = 1, mem_addr = 5, mem_wdata = 0x0007 in MEM.
  - Required: write_data unchanged.
- Branches: r1 = 7; 0x8510 at PC 2 → next imem_addr = 0x010. 0x9510 at PC 2 → next imem_addr = 3.
- Halt and reset mid-access:
  - 0xF000 → halted = 1 two cycles after its fetch. PC, mem_req and the registers then stay frozen for 20 cycles.
  - Assert reset during a MEM cycle → mem_req = 0 immediately; all reset values hold.
- WIDTH=32 regression: addi with imm 0x80 (sign-extended) gives 0xFFFFFF80; slt of 0xFFFFFF80 against 1 gives 1.
